// File: rtl/modbus_pkg.sv
// -----------------------------------------------------------------------------
// modbus_pkg
// Shared definitions for the Modbus RTU silence monitor:
//   - state_e           : framing FSM state encoding (INIT/IDLE/RX/GAP)
//   - FAST_T15_US/T35_US: fixed silence thresholds (us) used above 19200 baud
//   - CHAR_BITS_DEFAULT : default character length in bit times
// -----------------------------------------------------------------------------
package modbus_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,  // waiting for the initial 3.5T silence after reset
    ST_IDLE = 2'd1,  // line silent, no frame in progress
    ST_RX   = 2'd2,  // frame in progress, gap still below 1.5T
    ST_GAP  = 2'd3   // frame in progress, gap past 1.5T, waiting for 3.5T
  } state_e;

  localparam int unsigned FAST_T15_US       = 750;
  localparam int unsigned FAST_T35_US       = 1750;
  localparam int unsigned CHAR_BITS_DEFAULT = 11;

endpackage

// File: rtl/modbus_rtu_gap_timer_if.sv
// -----------------------------------------------------------------------------
// modbus_rtu_gap_timer_if
// Bundles the receiver-side inputs and framing outputs of the silence monitor.
//   master : drives bit_div, fast_mode, rx_done, rx_state; observes outputs
//   slave  : the gap timer itself
// Signals:
//   bit_div[DIV_W]  clocks per bit (0 treated as 1)
//   fast_mode       1 = fixed 750us/1750us thresholds
//   rx_done         1-cycle pulse per received byte
//   rx_state        high while the receiver is inside a character
//   ready           initial 3.5T silence has elapsed since reset
//   frame_active    high from SOF until EOF
//   sof/t15_pulse/eof 1-cycle event pulses
//   eof_err         valid with eof: a byte followed a 1.5T gap in this frame
//   byte_cnt[BCNT_W] bytes in the current frame (saturating, held after eof)
// -----------------------------------------------------------------------------
interface modbus_rtu_gap_timer_if #(
  parameter int DIV_W  = 16,
  parameter int BCNT_W = 8
);

  logic [DIV_W-1:0]  bit_div;
  logic              fast_mode;
  logic              rx_done;
  logic              rx_state;
  logic              ready;
  logic              frame_active;
  logic              sof;
  logic              t15_pulse;
  logic              eof;
  logic              eof_err;
  logic [BCNT_W-1:0] byte_cnt;

  modport master (
    output bit_div, fast_mode, rx_done, rx_state,
    input  ready, frame_active, sof, t15_pulse, eof, eof_err, byte_cnt
  );

  modport slave (
    input  bit_div, fast_mode, rx_done, rx_state,
    output ready, frame_active, sof, t15_pulse, eof, eof_err, byte_cnt
  );

endinterface

// File: rtl/modbus_gap_thresh.sv
// -----------------------------------------------------------------------------
// modbus_gap_thresh
// Converts the line configuration into registered 1.5T / 3.5T silence
// thresholds, in clock cycles.
//   clk, rst     clock, synchronous active-high reset (thresholds reload)
//   load_i       reload enable; thresholds are frozen while it is low
//   bit_div_i    clocks per bit (0 treated as 1)
//   fast_mode_i  1 = fixed 750us/1750us thresholds
//   t15_o/t35_o  registered thresholds, one cycle behind the inputs
// -----------------------------------------------------------------------------
module modbus_gap_thresh
  import modbus_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int CHAR_BITS = CHAR_BITS_DEFAULT,
  parameter int DIV_W     = 16,
  parameter int CNT_W     = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [DIV_W-1:0] bit_div_i,
  input  logic             fast_mode_i,
  output logic [CNT_W-1:0] t15_o,
  output logic [CNT_W-1:0] t35_o
);

  localparam int unsigned CLK_PER_US = CLK_FREQ / 1000000;
  localparam logic [CNT_W-1:0] FAST_T15 = CNT_W'(CLK_PER_US * FAST_T15_US);
  localparam logic [CNT_W-1:0] FAST_T35 = CNT_W'(CLK_PER_US * FAST_T35_US);
  localparam logic [CNT_W-1:0] MUL15    = CNT_W'(CHAR_BITS * 3);
  localparam logic [CNT_W-1:0] MUL35    = CNT_W'(CHAR_BITS * 7);

  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] prod15, prod35;
  logic [CNT_W-1:0] t15_d, t35_d;
  logic [CNT_W-1:0] t15_q, t35_q;

  // 1.5T and 3.5T are (3/2) and (7/2) character times; the halving is done
  // after the multiply so odd products round down.
  assign div    = (bit_div_i == '0) ? CNT_W'(1) : CNT_W'(bit_div_i);
  assign prod15 = div * MUL15;
  assign prod35 = div * MUL35;
  assign t15_d  = fast_mode_i ? FAST_T15 : (prod15 >> 1);
  assign t35_d  = fast_mode_i ? FAST_T35 : (prod35 >> 1);

  // NOTE: registers are written with non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst || load_i) begin
      t15_q <= t15_d;
      t35_q <= t35_d;
    end
  end

  assign t15_o = t15_q;
  assign t35_o = t35_q;

endmodule

// File: rtl/modbus_rtu_gap_timer.sv
// -----------------------------------------------------------------------------
// modbus_rtu_gap_timer
// Modbus RTU silence monitor beside the UART receiver. Counts idle clocks
// after each byte, compares against 1.5T/3.5T and frames the byte stream.
//   clk  system clock
//   rst  synchronous reset, active high (aborts any frame, back to INIT)
//   bus  modbus_rtu_gap_timer_if.slave: receiver inputs and framing outputs
// All outputs are registered; event pulses appear the cycle after the edge
// that detected them, aligned with the frame_active/ready level changes.
// -----------------------------------------------------------------------------
module modbus_rtu_gap_timer
  import modbus_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int CHAR_BITS = CHAR_BITS_DEFAULT,
  parameter int DIV_W     = 16,
  parameter int CNT_W     = 24,
  parameter int BCNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  modbus_rtu_gap_timer_if.slave bus
);

  logic [CNT_W-1:0]  t15, t35;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  state_e            state_q, state_d;
  logic              activity, cnt_inc, hit15, hit35;
  logic              thr_load;

  logic              ready_q, ready_d;
  logic              frame_active_q, frame_active_d;
  logic              sof_q, sof_d;
  logic              t15_q, t15_d;
  logic              eof_q, eof_d;
  logic              eof_err_q, eof_err_d;
  logic              err_q, err_d;
  logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d, byte_cnt_inc;

  // Thresholds only follow the configuration while no frame is in flight,
  // so a mid-frame reconfiguration cannot cause a spurious hit or miss.
  assign thr_load = (state_q == ST_INIT) || (state_q == ST_IDLE);

  modbus_gap_thresh #(
    .CLK_FREQ (CLK_FREQ),
    .CHAR_BITS(CHAR_BITS),
    .DIV_W    (DIV_W),
    .CNT_W    (CNT_W)
  ) u_thresh (
    .clk        (clk),
    .rst        (rst),
    .load_i     (thr_load),
    .bit_div_i  (bus.bit_div),
    .fast_mode_i(bus.fast_mode),
    .t15_o      (t15),
    .t35_o      (t35)
  );

  // Silence counter: any receiver activity restarts it; otherwise it climbs
  // to T35 and parks there. A hit is the increment that lands on a threshold,
  // so an activity cycle can never produce one.
  assign activity = bus.rx_done | bus.rx_state;
  assign cnt_inc  = !activity && (cnt_q < t35);
  assign hit15    = cnt_inc && ((cnt_q + CNT_W'(1)) == t15);
  assign hit35    = cnt_inc && ((cnt_q + CNT_W'(1)) == t35);

  always_comb begin
    cnt_d = cnt_q;
    if (activity)     cnt_d = '0;
    else if (cnt_inc) cnt_d = cnt_q + CNT_W'(1);
  end

  assign byte_cnt_inc = (byte_cnt_q == '1) ? byte_cnt_q : byte_cnt_q + BCNT_W'(1);

  always_comb begin
    // NOTE: every output of this block gets a default before the case, so
    // no path leaves a variable unassigned and no latch is inferred.
    state_d        = state_q;
    ready_d        = ready_q;
    frame_active_d = frame_active_q;
    sof_d          = 1'b0;
    t15_d          = 1'b0;
    eof_d          = 1'b0;
    eof_err_d      = 1'b0;
    err_d          = err_q;
    byte_cnt_d     = byte_cnt_q;

    unique case (state_q)
      ST_INIT: begin
        // Bytes seen before the line has been quiet for 3.5T are dropped;
        // they still restart the silence counter.
        if (hit35) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (bus.rx_done) begin
          state_d        = ST_RX;
          sof_d          = 1'b1;
          frame_active_d = 1'b1;
          byte_cnt_d     = BCNT_W'(1);
          err_d          = 1'b0;
        end
      end
      ST_RX: begin
        if (bus.rx_done) begin
          byte_cnt_d = byte_cnt_inc;
        end else if (hit15) begin
          state_d = ST_GAP;
          t15_d   = 1'b1;
        end
      end
      ST_GAP: begin
        if (bus.rx_done) begin
          state_d    = ST_RX;
          err_d      = 1'b1;
          byte_cnt_d = byte_cnt_inc;
        end else if (hit35) begin
          state_d        = ST_IDLE;
          eof_d          = 1'b1;
          eof_err_d      = err_q;
          frame_active_d = 1'b0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_INIT;
      cnt_q          <= '0;
      ready_q        <= 1'b0;
      frame_active_q <= 1'b0;
      sof_q          <= 1'b0;
      t15_q          <= 1'b0;
      eof_q          <= 1'b0;
      eof_err_q      <= 1'b0;
      err_q          <= 1'b0;
      byte_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ready_q        <= ready_d;
      frame_active_q <= frame_active_d;
      sof_q          <= sof_d;
      t15_q          <= t15_d;
      eof_q          <= eof_d;
      eof_err_q      <= eof_err_d;
      err_q          <= err_d;
      byte_cnt_q     <= byte_cnt_d;
    end
  end

  assign bus.ready        = ready_q;
  assign bus.frame_active = frame_active_q;
  assign bus.sof          = sof_q;
  assign bus.t15_pulse    = t15_q;
  assign bus.eof          = eof_q;
  assign bus.eof_err      = eof_err_q;
  assign bus.byte_cnt     = byte_cnt_q;

endmodule

// File: tb/tb_modbus_rtu_gap_timer.sv
// -----------------------------------------------------------------------------
// tb_modbus_rtu_gap_timer
// Directed bench: CLK_FREQ=1 MHz, bit_div=10, CHAR_BITS=11 gives T15=165,
// T35=385 cycles; fast mode gives 750/1750. Latencies are counted in clock
// edges from the edge that sampled the triggering input.
// -----------------------------------------------------------------------------
module tb_modbus_rtu_gap_timer;

  localparam int DIV_W  = 16;
  localparam int BCNT_W = 8;
  localparam int LIMIT  = 4000;

  localparam int SEL_READY = 0;
  localparam int SEL_T15   = 1;
  localparam int SEL_EOF   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_vec = 0;
  int n_err = 0;
  int sof_seen = 0;
  int t15_seen = 0;
  int eof_seen = 0;

  modbus_rtu_gap_timer_if #(.DIV_W(DIV_W), .BCNT_W(BCNT_W)) bus ();

  modbus_rtu_gap_timer #(
    .CLK_FREQ (1000000),
    .CHAR_BITS(11),
    .DIV_W    (DIV_W),
    .CNT_W    (24),
    .BCNT_W   (BCNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Event tallies, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.sof)       sof_seen++;
    if (bus.t15_pulse) t15_seen++;
    if (bus.eof)       eof_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rx();
    bus.rx_done = 1'b1;
    step();
    bus.rx_done = 1'b0;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      SEL_READY: return bus.ready;
      SEL_T15:   return bus.t15_pulse;
      SEL_EOF:   return bus.eof;
      default:   return 1'b0;
    endcase
  endfunction

  // Steps until the selected output is seen high; n is the edge count.
  task automatic wait_for(input int sel, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!sig(sel) && n < LIMIT);
  endtask

  initial begin
    int n;
    int t15_snap, eof_snap, sof_snap;

    bus.bit_div   = 16'd10;
    bus.fast_mode = 1'b0;
    bus.rx_done   = 1'b0;
    bus.rx_state  = 1'b0;

    // 1. Reset state and initial 3.5T silence.
    repeat (3) step();
    check("rst_ready", bus.ready, 0);
    check("rst_frame_active", bus.frame_active, 0);
    check("rst_byte_cnt", bus.byte_cnt, 0);
    check("rst_pulses", {bus.sof, bus.t15_pulse, bus.eof, bus.eof_err}, 0);
    rst = 1'b0;
    wait_for(SEL_READY, n);
    check("init_ready_latency", n, 385);
    check("init_no_sof_eof", sof_seen + eof_seen, 0);

    // 2. Three bytes 120 cycles apart, clean frame.
    t15_snap = t15_seen;
    pulse_rx();
    check("f2_sof", bus.sof, 1);
    check("f2_frame_active", bus.frame_active, 1);
    check("f2_first_cnt", bus.byte_cnt, 1);
    repeat (119) step();
    pulse_rx();
    check("f2_no_sof_mid", bus.sof, 0);
    repeat (119) step();
    pulse_rx();
    wait_for(SEL_EOF, n);
    check("f2_eof_latency", n, 385);
    check("f2_eof_err", bus.eof_err, 0);
    check("f2_byte_cnt", bus.byte_cnt, 3);
    check("f2_frame_inactive", bus.frame_active, 0);
    check("f2_t15_once", t15_seen - t15_snap, 1);

    // 3. New frame right after eof; 2nd byte 200 cycles late -> error.
    pulse_rx();
    check("f3_sof_after_eof", bus.sof, 1);
    check("f3_cnt_reload", bus.byte_cnt, 1);
    wait_for(SEL_T15, n);
    check("f3_t15_latency", n, 165);
    repeat (34) step();
    pulse_rx();
    wait_for(SEL_EOF, n);
    check("f3_eof_latency", n, 385);
    check("f3_eof_err", bus.eof_err, 1);
    check("f3_byte_cnt", bus.byte_cnt, 2);
    step();
    check("f3_cnt_held", bus.byte_cnt, 2);
    check("f3_eof_one_cycle", bus.eof, 0);

    // 4. Byte lands exactly on the would-be T15 hit.
    pulse_rx();
    t15_snap = t15_seen;
    repeat (164) step();
    pulse_rx();
    check("f4_no_t15_on_hit", bus.t15_pulse, 0);
    check("f4_no_t15_seen", t15_seen - t15_snap, 0);
    wait_for(SEL_T15, n);
    check("f4_t15_restart", n, 165);
    wait_for(SEL_EOF, n);
    check("f4_eof_after_t15", n, 220);
    check("f4_eof_err", bus.eof_err, 0);
    check("f4_byte_cnt", bus.byte_cnt, 2);

    // 5. Fast mode thresholds and rx_state holding off the counter.
    bus.fast_mode = 1'b1;
    bus.bit_div   = 16'd5;
    repeat (2) step();
    pulse_rx();
    wait_for(SEL_T15, n);
    check("f5_fast_t15", n, 750);
    wait_for(SEL_EOF, n);
    check("f5_fast_eof", n, 1000);
    pulse_rx();
    bus.rx_state = 1'b1;
    t15_snap = t15_seen;
    eof_snap = eof_seen;
    repeat (500) step();
    check("f5_busy_no_t15", t15_seen - t15_snap, 0);
    check("f5_busy_no_eof", eof_seen - eof_snap, 0);
    check("f5_busy_active", bus.frame_active, 1);
    bus.rx_state = 1'b0;
    wait_for(SEL_T15, n);
    check("f5_t15_after_busy", n, 750);
    wait_for(SEL_EOF, n);
    check("f5_eof_after_busy", n, 1000);
    check("f5_byte_cnt", bus.byte_cnt, 1);

    // Byte counter saturation on a long back-to-back burst.
    bus.fast_mode = 1'b0;
    bus.bit_div   = 16'd10;
    repeat (2) step();
    sof_snap = sof_seen;
    bus.rx_done = 1'b1;
    repeat (300) step();
    bus.rx_done = 1'b0;
    check("sat_byte_cnt", bus.byte_cnt, 255);
    check("sat_single_sof", sof_seen - sof_snap, 1);
    wait_for(SEL_EOF, n);
    check("sat_eof_latency", n, 385);

    // 6. Reset in the middle of a 4-byte frame.
    for (int i = 0; i < 4; i++) begin
      pulse_rx();
      repeat (10) step();
    end
    check("f6_byte_cnt", bus.byte_cnt, 4);
    check("f6_active", bus.frame_active, 1);
    eof_snap = eof_seen;
    sof_snap = sof_seen;
    rst = 1'b1;
    step();
    check("f6_rst_outputs",
          {bus.ready, bus.frame_active, bus.sof, bus.t15_pulse, bus.eof, bus.eof_err}, 0);
    check("f6_rst_byte_cnt", bus.byte_cnt, 0);
    step();
    rst = 1'b0;
    wait_for(SEL_READY, n);
    check("f6_ready_latency", n, 385);
    check("f6_no_eof", eof_seen - eof_snap, 0);
    check("f6_no_sof", sof_seen - sof_snap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
